// File: rtl/riscv_alu_seq_pkg.sv
// riscv_alu_seq_pkg: ALU operator encodings (riscv_defines ALU_* values),
// the divider FSM state type and small decode helpers for riscv_alu_seq.
// Optional feature macro used by the design: RISCV_ALU_SEQ_EARLY_TERM_EN.
package riscv_alu_seq_pkg;

  localparam int unsigned ALU_OP_WIDTH = 7;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD   = 7'b0011000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB   = 7'b0011001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR   = 7'b0101111;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR    = 7'b0101110;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND   = 7'b0010101;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA   = 7'b0100100;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL   = 7'b0100101;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL   = 7'b0100111;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LTS   = 7'b0000000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LTU   = 7'b0000001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LES   = 7'b0000100;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LEU   = 7'b0000101;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_GTS   = 7'b0001000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_GTU   = 7'b0001001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_GES   = 7'b0001010;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_GEU   = 7'b0001011;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_EQ    = 7'b0001100;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_NE    = 7'b0001101;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTS  = 7'b0000010;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU  = 7'b0000011;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLETS = 7'b0000110;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLETU = 7'b0000111;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_DIVU  = 7'b0110000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_DIV   = 7'b0110001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_REMU  = 7'b0110010;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_REM   = 7'b0110011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } riscv_alu_seq_state_e;

  function automatic logic is_div_op(input logic [ALU_OP_WIDTH-1:0] op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

  function automatic logic is_signed_cmp(input logic [ALU_OP_WIDTH-1:0] op);
    return (op == ALU_LTS) || (op == ALU_LES) || (op == ALU_GTS) || (op == ALU_GES) ||
           (op == ALU_SLTS) || (op == ALU_SLETS);
  endfunction

endpackage

// File: rtl/riscv_alu_seq_div.sv
// riscv_alu_seq_div: multi-cycle radix-2 restoring divider with a
// three-process IDLE/DIV/DONE FSM. Handles RISC-V divide-by-zero and
// signed-overflow results without iterating. With RISCV_ALU_SEQ_EARLY_TERM_EN
// defined, leading zeros of |dividend| are skipped by pre-shifting.
module riscv_alu_seq_div
  import riscv_alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_enable,
  input  logic             i_is_div,
  input  logic             i_signed,
  input  logic             i_rem,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_ex_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_ready,
  output logic             o_done
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  riscv_alu_seq_state_e r_state;
  riscv_alu_seq_state_e w_state_next;

  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_is_rem;
  logic [WIDTH-1:0] r_result;

  logic             w_accept;
  logic             w_b_zero;
  logic             w_ovf;
  logic             w_special;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_diff;
  logic             w_keep;
  logic [WIDTH:0]   w_rem_next;
  logic [WIDTH-1:0] w_quot_next;
  logic [WIDTH-1:0] w_rem_fin;
  logic [WIDTH-1:0] w_fixed;

  assign w_accept = i_enable && i_is_div;
  assign w_b_zero = (i_b == '0);
  assign w_ovf    = i_signed && (i_a == MIN_VAL) && (i_b == '1);
  assign w_abs_a  = (i_signed && i_a[WIDTH-1]) ? -i_a : i_a;
  assign w_abs_b  = (i_signed && i_b[WIDTH-1]) ? -i_b : i_b;

`ifdef RISCV_ALU_SEQ_EARLY_TERM_EN
  logic [CNT_W-1:0] w_lz;
  logic             w_a_zero;

  assign w_a_zero  = (w_abs_a == '0);
  assign w_special = w_b_zero || w_ovf || w_a_zero;

  // Leading-zero count of |dividend|; the highest set bit is the last match.
  always_comb begin
    w_lz = CNT_W'(WIDTH);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (w_abs_a[i]) w_lz = CNT_W'(WIDTH - 1 - i);
    end
  end
`else
  assign w_special = w_b_zero || w_ovf;
`endif

  // One restoring step: shift in the next dividend bit, keep the trial
  // subtraction when it does not go negative.
  always_comb begin
    w_shift     = {r_rem, r_quot[WIDTH-1]};
    w_diff      = w_shift - {2'b00, r_div};
    w_keep      = ~w_diff[WIDTH+1];
    w_rem_next  = w_keep ? w_diff[WIDTH:0] : w_shift[WIDTH:0];
    w_quot_next = {r_quot[WIDTH-2:0], w_keep};
    w_rem_fin   = w_rem_next[WIDTH-1:0];
    if (r_is_rem) w_fixed = r_neg_r ? -w_rem_fin : w_rem_fin;
    else          w_fixed = r_neg_q ? -w_quot_next : w_quot_next;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = w_special ? DONE : DIV;
      DIV:     if (r_cnt == CNT_W'(1)) w_state_next = DONE;
      DONE:    if (i_ex_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    o_ready = 1'b1;
    o_done  = 1'b0;
    case (r_state)
      IDLE:    o_ready = ~w_accept;
      DIV:     o_ready = 1'b0;
      DONE:    o_done  = 1'b1;
      default: o_ready = 1'b1;
    endcase
  end

  // Divider datapath: operand capture, iteration, and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quot   <= '0;
      r_div    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_rem <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_div    <= w_abs_b;
            r_neg_q  <= i_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            r_neg_r  <= i_signed && i_a[WIDTH-1];
            r_is_rem <= i_rem;
            r_rem    <= '0;
`ifdef RISCV_ALU_SEQ_EARLY_TERM_EN
            r_quot   <= w_abs_a << w_lz;
            r_cnt    <= CNT_W'(WIDTH) - w_lz;
`else
            r_quot   <= w_abs_a;
            r_cnt    <= CNT_W'(WIDTH);
`endif
            if (w_b_zero)  r_result <= i_rem ? i_a : '1;
            else if (w_ovf) r_result <= i_rem ? '0 : MIN_VAL;
`ifdef RISCV_ALU_SEQ_EARLY_TERM_EN
            else if (w_a_zero) r_result <= '0;
`endif
          end
        end
        DIV: begin
          r_rem  <= w_rem_next;
          r_quot <= w_quot_next;
          r_cnt  <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_result <= w_fixed;
        end
        default: ;
      endcase
    end
  end

  assign o_result = r_result;

endmodule

// File: rtl/riscv_alu_seq.sv
// riscv_alu_seq: EX-stage integer ALU. Single-cycle logic/shift/compare ops
// are combinational; DIV/DIVU/REM/REMU go through riscv_alu_seq_div with a
// ready_o / ex_ready_i handshake.
// Optional feature macro: RISCV_ALU_SEQ_EARLY_TERM_EN (divider early exit).
module riscv_alu_seq
  import riscv_alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable_i,
  input  logic [ALU_OP_WIDTH-1:0] operator_i,
  input  logic [WIDTH-1:0]        operand_a_i,
  input  logic [WIDTH-1:0]        operand_b_i,
  output logic [WIDTH-1:0]        result_o,
  output logic                    comparison_result_o,
  output logic                    ready_o,
  input  logic                    ex_ready_i
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic [SHW-1:0]   w_shamt;
  logic             w_cmp_signed;
  logic [WIDTH:0]   w_a_ext;
  logic [WIDTH:0]   w_b_ext;
  logic             w_lt;
  logic             w_eq;
  logic             w_cmp;
  logic [WIDTH-1:0] w_alu_result;
  logic             w_supported;
  logic             w_is_div;
  logic             w_div_signed;
  logic             w_div_rem;
  logic [WIDTH-1:0] w_div_result;
  logic             w_div_ready;
  logic             w_div_done;

  assign w_shamt      = operand_b_i[SHW-1:0];
  assign w_cmp_signed = is_signed_cmp(operator_i);
  assign w_a_ext      = {operand_a_i[WIDTH-1] & w_cmp_signed, operand_a_i};
  assign w_b_ext      = {operand_b_i[WIDTH-1] & w_cmp_signed, operand_b_i};
  assign w_lt         = $signed(w_a_ext) < $signed(w_b_ext);
  assign w_eq         = (operand_a_i == operand_b_i);

  assign w_is_div     = is_div_op(operator_i);
  assign w_div_signed = (operator_i == ALU_DIV) || (operator_i == ALU_REM);
  assign w_div_rem    = (operator_i == ALU_REM) || (operator_i == ALU_REMU);

  // Single-cycle result and branch compare, decoded from the operator.
  always_comb begin
    w_alu_result = '0;
    w_cmp        = 1'b0;
    w_supported  = 1'b1;
    case (operator_i)
      ALU_ADD:   w_alu_result = operand_a_i + operand_b_i;
      ALU_SUB:   w_alu_result = operand_a_i - operand_b_i;
      ALU_AND:   w_alu_result = operand_a_i & operand_b_i;
      ALU_OR:    w_alu_result = operand_a_i | operand_b_i;
      ALU_XOR:   w_alu_result = operand_a_i ^ operand_b_i;
      ALU_SLL:   w_alu_result = operand_a_i << w_shamt;
      ALU_SRL:   w_alu_result = operand_a_i >> w_shamt;
      ALU_SRA:   w_alu_result = $signed(operand_a_i) >>> w_shamt;
      ALU_LTS, ALU_LTU: begin
        w_cmp        = w_lt;
        w_alu_result = {WIDTH{w_cmp}};
      end
      ALU_LES, ALU_LEU: begin
        w_cmp        = w_lt | w_eq;
        w_alu_result = {WIDTH{w_cmp}};
      end
      ALU_GTS, ALU_GTU: begin
        w_cmp        = ~(w_lt | w_eq);
        w_alu_result = {WIDTH{w_cmp}};
      end
      ALU_GES, ALU_GEU: begin
        w_cmp        = ~w_lt;
        w_alu_result = {WIDTH{w_cmp}};
      end
      ALU_EQ: begin
        w_cmp        = w_eq;
        w_alu_result = {WIDTH{w_cmp}};
      end
      ALU_NE: begin
        w_cmp        = ~w_eq;
        w_alu_result = {WIDTH{w_cmp}};
      end
      ALU_SLTS, ALU_SLTU: begin
        w_cmp        = w_lt;
        w_alu_result = {{(WIDTH-1){1'b0}}, w_cmp};
      end
      ALU_SLETS, ALU_SLETU: begin
        w_cmp        = w_lt | w_eq;
        w_alu_result = {{(WIDTH-1){1'b0}}, w_cmp};
      end
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: w_alu_result = '0;
      default:   w_supported = 1'b0;
    endcase
  end

  riscv_alu_seq_div #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_enable   (enable_i),
    .i_is_div   (w_is_div),
    .i_signed   (w_div_signed),
    .i_rem      (w_div_rem),
    .i_a        (operand_a_i),
    .i_b        (operand_b_i),
    .i_ex_ready (ex_ready_i),
    .o_result   (w_div_result),
    .o_ready    (w_div_ready),
    .o_done     (w_div_done)
  );

  assign result_o            = w_div_done ? w_div_result : w_alu_result;
  assign comparison_result_o = w_cmp;
  assign ready_o             = w_div_ready;

`ifndef SYNTHESIS
  // Flag requests carrying an operator this ALU does not implement.
  always_ff @(posedge clk) begin
    if (!rst && enable_i && !w_supported)
      $warning("riscv_alu_seq: unsupported operator 0x%0h", operator_i);
  end
`endif

endmodule

// File: tb/tb_riscv_alu_seq.sv
// Self-checking bench for riscv_alu_seq (WIDTH=32), valid with or without
// RISCV_ALU_SEQ_EARLY_TERM_EN: expected divider latency follows the macro.
module tb_riscv_alu_seq;
  import riscv_alu_seq_pkg::*;

  localparam int unsigned W = 32;
  localparam logic [31:0] MINV = 32'h8000_0000;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    enable_i;
  logic [ALU_OP_WIDTH-1:0] operator_i;
  logic [W-1:0]            operand_a_i;
  logic [W-1:0]            operand_b_i;
  logic [W-1:0]            result_o;
  logic                    comparison_result_o;
  logic                    ready_o;
  logic                    ex_ready_i;

  riscv_alu_seq #(.WIDTH(W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .enable_i            (enable_i),
    .operator_i          (operator_i),
    .operand_a_i         (operand_a_i),
    .operand_b_i         (operand_b_i),
    .result_o            (result_o),
    .comparison_result_o (comparison_result_o),
    .ready_o             (ready_o),
    .ex_ready_i          (ex_ready_i)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  typedef struct {
    logic [6:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        cmp;
  } vec_t;

  // Reference: compare outcome straight from signed/unsigned arithmetic.
  function automatic logic ref_cmp(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = $signed(a);
    longint sb = $signed(b);
    case (op)
      ALU_LTS, ALU_SLTS:   return sa < sb;
      ALU_LTU, ALU_SLTU:   return a < b;
      ALU_LES, ALU_SLETS:  return sa <= sb;
      ALU_LEU, ALU_SLETU:  return a <= b;
      ALU_GTS:             return sa > sb;
      ALU_GTU:             return a > b;
      ALU_GES:             return sa >= sb;
      ALU_GEU:             return a >= b;
      ALU_EQ:              return a == b;
      ALU_NE:              return a != b;
      default:             return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_alu(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
    logic c;
    logic [31:0] r;
    c = ref_cmp(op, a, b);
    case (op)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_SLL: r = a << b[4:0];
      ALU_SRL: r = a >> b[4:0];
      ALU_SRA: r = $signed(a) >>> b[4:0];
      ALU_SLTS, ALU_SLTU, ALU_SLETS, ALU_SLETU: r = {31'b0, c};
      ALU_LTS, ALU_LTU, ALU_LES, ALU_LEU, ALU_GTS, ALU_GTU,
      ALU_GES, ALU_GEU, ALU_EQ, ALU_NE: r = {32{c}};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] ref_div(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
    logic   sgn = (op == ALU_DIV) || (op == ALU_REM);
    logic   rem = (op == ALU_REM) || (op == ALU_REMU);
    longint sa  = $signed(a);
    longint sb  = $signed(b);
    if (b == 0) return rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == MINV && b == 32'hFFFF_FFFF) return rem ? 32'h0 : MINV;
    if (sgn) return rem ? 32'(sa % sb) : 32'(sa / sb);
    return rem ? a % b : a / b;
  endfunction

  // Cycles from the request cycle to the first cycle ready_o is high again.
  function automatic int exp_lat(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
    logic sgn = (op == ALU_DIV) || (op == ALU_REM);
    logic [31:0] mag;
    int lz;
    if (b == 0) return 1;
    if (sgn && a == MINV && b == 32'hFFFF_FFFF) return 1;
    mag = (sgn && a[31]) ? -a : a;
    lz = 0;
    while (lz < 32 && mag[31-lz] == 1'b0) lz++;
`ifdef RISCV_ALU_SEQ_EARLY_TERM_EN
    if (lz == 32) return 1;
    return 32 - lz + 1;
`else
    return (lz > 99) ? 0 : 33;
`endif
  endfunction

  // Issue a divide from an idle ALU; returns result_o and cycles to ready_o.
  task automatic run_div(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic keep_en, output logic [31:0] res, output int lat);
    enable_i    = 1'b1;
    operator_i  = op;
    operand_a_i = a;
    operand_b_i = b;
    #1;
    check("req_ready_low", ready_o, 1'b0);
    lat = 0;
    do begin
      @(posedge clk); #1;
      if (!keep_en) enable_i = 1'b0;
      lat++;
    end while (ready_o !== 1'b1 && lat < 200);
    if (lat >= 200) check("div_timeout", 1'b0, 1'b1);
    res = result_o;
  endtask

  task automatic check_div(input string name, input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    int lat;
    run_div(op, a, b, 1'b0, r, lat);
    check({name, "_res"}, r, ref_div(op, a, b));
    check({name, "_lat"}, lat, exp_lat(op, a, b));
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    logic [6:0] sc_ops[22] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
                               ALU_LTS, ALU_LTU, ALU_LES, ALU_LEU, ALU_GTS, ALU_GTU, ALU_GES, ALU_GEU,
                               ALU_EQ, ALU_NE, ALU_SLTS, ALU_SLTU, ALU_SLETS, ALU_SLETU};
    logic [6:0] dv_ops[4] = '{ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    logic [31:0] r;
    int lat, lat2;

    vecs.push_back('{ALU_ADD,   32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0});
    vecs.push_back('{ALU_SRA,   32'h8000_0000, 32'h4,         32'hF800_0000, 1'b0});
    vecs.push_back('{ALU_SLTS,  32'hFFFF_FFFF, 32'h1,         32'h0000_0001, 1'b1});
    vecs.push_back('{ALU_SUB,   32'h5,         32'h7,         32'hFFFF_FFFE, 1'b0});
    vecs.push_back('{ALU_AND,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0});
    vecs.push_back('{ALU_OR,    32'h0F0F_0000, 32'h0000_00FF, 32'h0F0F_00FF, 1'b0});
    vecs.push_back('{ALU_XOR,   32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 1'b0});
    vecs.push_back('{ALU_SLL,   32'h1,         32'h21,        32'h2,         1'b0});
    vecs.push_back('{ALU_SRL,   32'h8000_0000, 32'h1F,        32'h1,         1'b0});
    vecs.push_back('{ALU_LTU,   32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0});
    vecs.push_back('{ALU_LTS,   32'hFFFF_FFFF, 32'h1,         32'hFFFF_FFFF, 1'b1});
    vecs.push_back('{ALU_GES,   32'h8000_0000, 32'h7FFF_FFFF, 32'h0,         1'b0});
    vecs.push_back('{ALU_GEU,   32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1});
    vecs.push_back('{ALU_EQ,    32'h1234,      32'h1234,      32'hFFFF_FFFF, 1'b1});
    vecs.push_back('{ALU_NE,    32'h1234,      32'h1234,      32'h0,         1'b0});
    vecs.push_back('{ALU_LES,   32'h5,         32'h5,         32'hFFFF_FFFF, 1'b1});
    vecs.push_back('{ALU_GTU,   32'h5,         32'h5,         32'h0,         1'b0});
    vecs.push_back('{ALU_GTS,   32'h1,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1});
    vecs.push_back('{ALU_SLETU, 32'h5,         32'h5,         32'h1,         1'b1});
    vecs.push_back('{ALU_SLTU,  32'h1,         32'hFFFF_FFFF, 32'h1,         1'b1});
    vecs.push_back('{7'h7F,     32'h5,         32'h3,         32'h0,         1'b0});

    rst = 1'b1; enable_i = 1'b0; ex_ready_i = 1'b1;
    operator_i = ALU_ADD; operand_a_i = '0; operand_b_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", ready_o, 1'b1);
    check("reset_result", result_o, 32'h0);
    check("reset_cnt", dut.u_div.r_cnt, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single-cycle table.
    foreach (vecs[i]) begin
      enable_i    = (vecs[i].op != 7'h7F);
      operator_i  = vecs[i].op;
      operand_a_i = vecs[i].a;
      operand_b_i = vecs[i].b;
      #2;
      check($sformatf("vec%0d_res", i), result_o, vecs[i].res);
      check($sformatf("vec%0d_cmp", i), comparison_result_o, vecs[i].cmp);
      check($sformatf("vec%0d_rdy", i), ready_o, 1'b1);
      @(posedge clk); #1;
    end
    enable_i = 1'b0;

    // Directed divides.
    check_div("divu_100_7", ALU_DIVU, 32'd100, 32'd7);
    check_div("remu_100_7", ALU_REMU, 32'd100, 32'd7);
    check_div("div_m7_2",   ALU_DIV,  32'hFFFF_FFF9, 32'd2);
    check_div("rem_m7_2",   ALU_REM,  32'hFFFF_FFF9, 32'd2);
    check_div("div_ovf",    ALU_DIV,  MINV, 32'hFFFF_FFFF);
    check_div("rem_ovf",    ALU_REM,  MINV, 32'hFFFF_FFFF);
    check_div("divu_5_0",   ALU_DIVU, 32'd5, 32'd0);
    check_div("remu_5_0",   ALU_REMU, 32'd5, 32'd0);
    check_div("rem_m5_0",   ALU_REM,  32'hFFFF_FFFB, 32'd0);
    check_div("divu_3_1",   ALU_DIVU, 32'd3, 32'd1);
    check_div("divu_0_9",   ALU_DIVU, 32'd0, 32'd9);
    check_div("div_7_m2",   ALU_DIV,  32'd7, 32'hFFFF_FFFE);

    // Result held while EX stage stalls.
    ex_ready_i = 1'b0;
    run_div(ALU_DIVU, 32'd20, 32'd3, 1'b0, r, lat);
    check("hold_res", r, 32'd6);
    check("hold_lat", lat, exp_lat(ALU_DIVU, 32'd20, 32'd3));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check($sformatf("hold%0d_res", i), result_o, 32'd6);
      check($sformatf("hold%0d_rdy", i), ready_o, 1'b1);
    end
    ex_ready_i = 1'b1;
    @(posedge clk); #1;
    check("release_idle_res", result_o, 32'h0);
    check("release_idle_rdy", ready_o, 1'b1);

    // Reset in the middle of a divide.
    enable_i = 1'b1; operator_i = ALU_DIVU; operand_a_i = 32'd1000; operand_b_i = 32'd3;
    @(posedge clk); #1;
    enable_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("mid_busy", ready_o, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_ready", ready_o, 1'b1);
    check("rst_result", result_o, 32'h0);
    check("rst_reg_result", dut.u_div.r_result, 32'h0);
    check("rst_reg_quot", dut.u_div.r_quot, 32'h0);
    check_div("after_rst_9_3", ALU_DIVU, 32'd9, 32'd3);

    // enable_i held through DONE: new request only in the following cycle.
    run_div(ALU_DIVU, 32'd20, 32'd3, 1'b1, r, lat);
    check("b2b_first_res", r, 32'd6);
    @(posedge clk); #1;
    check("b2b_accept_rdy", ready_o, 1'b0);
    lat2 = 0;
    do begin
      @(posedge clk); #1;
      lat2++;
    end while (ready_o !== 1'b1 && lat2 < 200);
    enable_i = 1'b0;
    check("b2b_second_lat", lat2, exp_lat(ALU_DIVU, 32'd20, 32'd3));
    check("b2b_second_res", result_o, 32'd6);
    @(posedge clk); #1;

    // Random single-cycle ops.
    for (int i = 0; i < 60; i++) begin
      logic [6:0]  op;
      logic [31:0] a, b;
      op = sc_ops[$urandom_range(0, 21)];
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      enable_i = 1'b1; operator_i = op; operand_a_i = a; operand_b_i = b;
      #2;
      check($sformatf("rnd_sc%0d_res", i), result_o, ref_alu(op, a, b));
      check($sformatf("rnd_sc%0d_cmp", i), comparison_result_o, ref_cmp(op, a, b));
      check($sformatf("rnd_sc%0d_rdy", i), ready_o, 1'b1);
      @(posedge clk); #1;
    end
    enable_i = 1'b0;

    // Random divides, with operand bias toward the special cases.
    for (int i = 0; i < 60; i++) begin
      logic [6:0]  op;
      logic [31:0] a, b;
      op = dv_ops[$urandom_range(0, 3)];
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 6))
        0: b = 32'h0;
        1: begin a = MINV; b = 32'hFFFF_FFFF; end
        2: a = $urandom_range(0, 255);
        3: b = $urandom_range(1, 15);
        4: a = 32'h0;
        default: ;
      endcase
      check_div($sformatf("rnd_div%0d", i), op, a, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/riscv_alu_seq.md
Name: riscv_alu_seq

Overview:
- Parametrised-width integer ALU and successor to the single-cycle basic ALU.
- Keeps the single-cycle logic, shift and compare operations.
- Adds a multi-cycle radix-2 restoring divider for ALU_DIV/ALU_DIVU/ALU_REM/ALU_REMU, with a ready/ex_ready handshake toward the EX stage.
- Sits in the EX stage in place of the basic ALU, for cores without a shared DSP divider.

Parameters:
- WIDTH, 32, datapath width in bits; power of two, 8..64.
- CNT_W, $clog2(WIDTH)+1, iteration-counter width; derived, not to be overridden.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- enable_i  in  1  operation valid this cycle
- operator_i  in  ALU_OP_WIDTH  operation code, riscv_defines ALU_* encoding
- operand_a_i  in  WIDTH  operand A / dividend
- operand_b_i  in  WIDTH  operand B / divisor / shift amount
- result_o  out  WIDTH  result
- comparison_result_o  out  1  branch compare result
- ready_o  out  1  result valid / ALU able to accept
- ex_ready_i  in  1  downstream consumes result

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, on port rst.
- Single-cycle ops:
  - Covered: AND, OR, XOR, ADD, SUB, SLL, SRL, SRA, EQ/NE/GT/GE/LT/LE (S/U), SLTS/SLTU/SLETS/SLETU.
  - result_o and comparison_result_o are combinational from the operands. ready_o=1. No state change.
  - Shift amount is operand_b_i[$clog2(WIDTH)-1:0].
  - Compare results fill all WIDTH bits. SLT-type ops return a zero-extended single bit.
- Unsupported operator: result_o=0, comparison_result_o=0, ready_o=1. Simulation emits $warning, guarded by `ifndef SYNTHESIS.
- FSM states: IDLE, DIV, DONE. Reset puts the FSM in IDLE.
- Reset values: counter=0, quotient/remainder/divisor registers=0, ready_o=1 (IDLE, no request), comparison_result_o follows operands.
- IDLE:
  - On enable_i with a div op: latch |a|, |b|, signs, op kind; counter=WIDTH.
  - Next state is DIV, or DONE directly on divide-by-zero or signed overflow.
  - ready_o=0 in that request cycle.
- DIV:
  - One quotient bit per cycle, MSB first.
  - Remainder is WIDTH+1 bits wide; a trial subtract keeps the bit when the result is non-negative.
  - Counter decrements each cycle; at 1, transition to DONE.
  - ready_o=0 throughout. enable_i and operands are ignored.
- DONE:
  - result_o = registered result: quotient or remainder, with sign fix-up applied on entry to DONE. ready_o=1.
  - If ex_ready_i=1: go to IDLE.
  - If ex_ready_i=0: hold result_o stable indefinitely.
- Latency: accept at cycle 0, DONE at cycle WIDTH+1, so a 32-bit divide takes 33 cycles to ready_o. Special cases reach DONE at cycle 1.
- Special cases (RISC-V semantics):
  - Div by 0: quotient = all ones; remainder = dividend.
  - Signed MIN / -1: quotient = MIN; remainder = 0.
- Sign rules: quotient negative iff signs differ and the divisor is nonzero. Remainder takes the dividend's sign.
- DONE with enable_i high and ex_ready_i high: return to IDLE; a new request is accepted next cycle, not the same cycle.
- rst asserted in DIV or DONE: IDLE on the next edge, result registers cleared, no output pulse.
- Comparison unit works on WIDTH-bit signed/unsigned operands, using {msb&signed, x} extension.

Optional Feature:
- Macro: RISCV_ALU_SEQ_EARLY_TERM_EN.
- Defined:
  - On accept, count leading zeros of |a| (lz).
  - Pre-shift the dividend left by lz and set counter = WIDTH-lz.
  - Dividend 0 goes straight to DONE at cycle 1.
  - Latency = WIDTH-lz+1. Results are bit-identical.
- Undefined: fixed WIDTH-iteration latency as above; no leading-zero logic synthesised.

Decomposition:
- riscv_defines gains riscv_alu_seq_state_e {IDLE, DIV, DONE} (2-bit enum).
- Reuse the existing ALU_DIV/ALU_DIVU/ALU_REM/ALU_REMU codes; no new opcodes.
- One sub-module, riscv_alu_seq_div, holds the FSM, counter, divider datapath and optional leading-zero counter.
- The top level holds the combinational ops, the result mux and ready_o.

Test Plan:
- ADD 0x7FFFFFFF+1, SRA 0x80000000 by 4, SLTS -1<1 → 0x80000000, 0xF8000000, 0x00000001, each with ready_o=1 in the same cycle.
- DIVU 100/7 → ready_o low cycles 0..32, high at cycle 33, result_o=14. REMU on the same operands gives 2.
- DIV -7/2 → -3 (0xFFFFFFFD). REM -7/2 → -1. DIV 0x80000000/-1 → 0x80000000 at cycle 1. DIVU 5/0 → 0xFFFFFFFF. REMU 5/0 → 5.
- DIVU 20/3, hold ex_ready_i=0 for 10 cycles after DONE → result_o stays 6 and ready_o stays 1. Raising ex_ready_i returns the FSM to IDLE next cycle.
- Assert rst at cycle 10 of a DIV → next cycle in IDLE, ready_o=1, registers 0. A following DIVU 9/3 returns 3.
- With RISCV_ALU_SEQ_EARLY_TERM_EN: DIVU 3/1 (lz=30) → ready_o at cycle 3, result 3. DIVU 0/9 → 0 at cycle 1. Repeat at WIDTH=8 and WIDTH=64 for random operands against a reference model.
